// File: rtl/wb_fifo_ctrl.sv
// rtl/wb_fifo_ctrl.sv - Wishbone controller sharing one strobe-driven FIFO between the CPU and a hardware producer
module wb_fifo_ctrl #(
    parameter int DATO_WIDTH  = 8,
    parameter int FIFO_LENGTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [3:0]            wb_adr_i,
    input  logic [31:0]           wb_dat_i,
    output logic [31:0]           wb_dat_o,
    output logic                  wb_ack_o,
    input  logic                  prod_valid,
    input  logic [DATO_WIDTH-1:0] prod_data,
    output logic                  prod_ready,
    output logic [DATO_WIDTH-1:0] fifo_din,
    output logic                  fifo_wr,
    output logic                  fifo_rd,
    output logic                  fifo_rst,
    input  logic [DATO_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_full,
    input  logic                  fifo_empty,
    output logic                  irq
);

    localparam int LW = FIFO_LENGTH + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(1 << FIFO_LENGTH);
    localparam logic [LW-1:0] LVL_ONE = LW'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_PUSH, S_POP, S_REG, S_SETTLE, S_ACK
    } state_t;

    state_t                  state, state_nxt;
    logic [LW-1:0]           level;
    logic                    irq_en, prod_en, ovf, udf;
    logic [7:0]              threshold;
    logic                    last_grant;
    logic                    grant_prod;
    logic                    op_pop;
    logic [1:0]              adr_q;
    logic                    we_q;
    logic [31:0]             wdat_q;
    logic [DATO_WIDTH-1:0]   pop_q;

    logic blocked_full, blocked_empty, thr_hit;
    logic cpu_req, prod_req, grant_cpu, grant_p;
    logic [31:0] status_word, ctrl_word, reg_rdata;
    logic unused_ok;

    assign blocked_full  = fifo_full | (level == DEPTH_L);
    assign blocked_empty = fifo_empty | (level == '0);
    assign thr_hit       = (32'(level) >= 32'(threshold)) & (threshold != 8'd0);

    // Round-robin: on contention, the side that did not win last time gets the grant.
    assign cpu_req   = wb_cyc_i & wb_stb_i;
    assign prod_req  = prod_valid & prod_en & ~blocked_full;
    assign grant_cpu = cpu_req & (~prod_req | last_grant);
    assign grant_p   = prod_req & (~cpu_req | ~last_grant);

    assign unused_ok = ^{wdat_q, wb_adr_i[1:0]};

    always_comb begin
        status_word       = '0;
        status_word[0]    = blocked_empty;
        status_word[1]    = blocked_full;
        status_word[2]    = thr_hit;
        status_word[3]    = ovf;
        status_word[4]    = udf;
        status_word[15:8] = 8'(level);
        ctrl_word         = '0;
        ctrl_word[0]      = irq_en;
        ctrl_word[1]      = prod_en;
        ctrl_word[15:8]   = threshold;
        case (adr_q)
            2'd1:    reg_rdata = status_word;
            2'd2:    reg_rdata = ctrl_word;
            default: reg_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (grant_cpu) begin
                    if (wb_adr_i[3:2] == 2'd0) state_nxt = wb_we_i ? S_PUSH : S_POP;
                    else                       state_nxt = S_REG;
                end else if (grant_p) begin
                    state_nxt = S_PUSH;
                end
            end
            S_PUSH, S_POP: state_nxt = S_SETTLE;
            S_REG:         state_nxt = S_IDLE;
            S_SETTLE:      state_nxt = (grant_prod | ~wb_cyc_i) ? S_IDLE : S_ACK;
            S_ACK:         state_nxt = S_IDLE;
            default:       state_nxt = S_IDLE;
        endcase
    end

    // Register accesses are acknowledged in the REG cycle itself for single-cycle latency.
    always_comb begin
        fifo_wr    = 1'b0;
        fifo_rd    = 1'b0;
        fifo_din   = '0;
        prod_ready = 1'b0;
        wb_ack_o   = 1'b0;
        wb_dat_o   = '0;
        case (state)
            S_PUSH: begin
                fifo_wr    = grant_prod | ~blocked_full;
                prod_ready = grant_prod;
                if (fifo_wr) fifo_din = grant_prod ? prod_data : wdat_q[DATO_WIDTH-1:0];
            end
            S_POP: fifo_rd = ~blocked_empty;
            S_REG: begin
                wb_ack_o = wb_cyc_i;
                wb_dat_o = we_q ? '0 : reg_rdata;
            end
            S_ACK: begin
                wb_ack_o = 1'b1;
                wb_dat_o = op_pop ? 32'(pop_q) : '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level      <= '0;
            irq_en     <= 1'b0;
            prod_en    <= 1'b0;
            threshold  <= '0;
            ovf        <= 1'b0;
            udf        <= 1'b0;
            last_grant <= 1'b0;
            grant_prod <= 1'b0;
            op_pop     <= 1'b0;
            adr_q      <= '0;
            we_q       <= 1'b0;
            wdat_q     <= '0;
            pop_q      <= '0;
            fifo_rst   <= 1'b1;
            irq        <= 1'b0;
        end else begin
            fifo_rst <= 1'b0;
            irq      <= irq_en & (thr_hit | ovf | udf);

            if (fifo_rst)                        level <= '0;
            else if (fifo_wr && level != DEPTH_L) level <= level + LVL_ONE;
            else if (fifo_rd && level != '0)      level <= level - LVL_ONE;

            case (state)
                S_IDLE: begin
                    if (grant_cpu) begin
                        grant_prod <= 1'b0;
                        last_grant <= 1'b0;
                        adr_q      <= wb_adr_i[3:2];
                        we_q       <= wb_we_i;
                        wdat_q     <= wb_dat_i;
                        op_pop     <= (wb_adr_i[3:2] == 2'd0) & ~wb_we_i;
                    end else if (grant_p) begin
                        grant_prod <= 1'b1;
                        last_grant <= 1'b1;
                        op_pop     <= 1'b0;
                    end
                end
                S_PUSH: if (!grant_prod && blocked_full) ovf <= 1'b1;
                S_POP: begin
                    if (blocked_empty) begin
                        udf   <= 1'b1;
                        pop_q <= '0;
                    end else begin
                        pop_q <= fifo_dout;
                    end
                end
                S_REG: begin
                    if (we_q && adr_q == 2'd2) begin
                        irq_en    <= wdat_q[0];
                        prod_en   <= wdat_q[1];
                        threshold <= wdat_q[15:8];
                        fifo_rst  <= wdat_q[2];
                    end
                    if (we_q && adr_q == 2'd3) begin
                        if (wdat_q[3]) ovf <= 1'b0;
                        if (wdat_q[4]) udf <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
